// File: rtl/per2slave_rr_arb_if.sv
// Bus bundle between the address decoders, the round-robin arbiter and one slave port.
// The "slave" modport is the arbiter view (it serves the requesting masters); the
// "master" modport is the surrounding environment (decoders plus the downstream slave).
interface per2slave_rr_arb_if #(
    parameter int unsigned N_MASTER   = 16,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 17
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    // Master (decoder) side
    logic [N_MASTER-1:0]                 data_req_i;
    logic [N_MASTER-1:0][ADDR_WIDTH-1:0] data_add_i;
    logic [N_MASTER-1:0]                 data_wen_i;
    logic [N_MASTER-1:0][DATA_WIDTH-1:0] data_wdata_i;
    logic [N_MASTER-1:0][BE_WIDTH-1:0]   data_be_i;
    logic [N_MASTER-1:0][ID_WIDTH-1:0]   data_ID_i;
    logic [N_MASTER-1:0]                 data_gnt_o;

    // Slave side
    logic                  data_req_o;
    logic [ADDR_WIDTH-1:0] data_add_o;
    logic                  data_wen_o;
    logic [DATA_WIDTH-1:0] data_wdata_o;
    logic [BE_WIDTH-1:0]   data_be_o;
    logic [ID_WIDTH-1:0]   data_ID_o;
    logic                  data_gnt_i;

    modport slave (
        input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
        output data_gnt_o,
        output data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o,
        input  data_gnt_i
    );

    modport master (
        output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
        input  data_gnt_o,
        input  data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o,
        output data_gnt_i
    );
endinterface

// File: rtl/per2slave_rr_arb.sv
// Round-robin arbiter from N_MASTER decoder ports onto one registered slave request.
// A single output register holds the winning request; a new winner is taken whenever
// that register is empty or is being drained this cycle, giving one transfer per cycle.
module per2slave_rr_arb #(
    parameter int unsigned N_MASTER   = 16,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 17
) (
    input  logic                clk,
    input  logic                rst_n,
    per2slave_rr_arb_if.slave   bus
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned PTR_W    = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

    logic                  valid_q, valid_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ADDR_WIDTH-1:0] add_q, add_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE_WIDTH-1:0]   be_q, be_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;

    logic                  free;
    logic                  found;
    logic                  capture;
    logic [PTR_W-1:0]      winner;

    // Search for the first requester at or above rr_ptr, wrapping at N_MASTER-1
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < N_MASTER; i++) begin
            int unsigned idx;
            idx = 32'(rr_ptr_q) + i;
            if (idx >= N_MASTER) idx = idx - N_MASTER;
            if (!found && bus.data_req_i[PTR_W'(idx)]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    // Grant generation and next-state for the output register and pointer
    always_comb begin
        free       = !valid_q || bus.data_gnt_i;
        capture    = free && found;
        bus.data_gnt_o = '0;
        valid_d    = valid_q;
        rr_ptr_d   = rr_ptr_q;
        add_d      = add_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        id_d       = id_q;
        if (capture) begin
            bus.data_gnt_o[winner] = 1'b1;
            valid_d = 1'b1;
            add_d   = bus.data_add_i[winner];
            wen_d   = bus.data_wen_i[winner];
            wdata_d = bus.data_wdata_i[winner];
            be_d    = bus.data_be_i[winner];
            id_d    = bus.data_ID_i[winner];
            if (32'(winner) == N_MASTER - 1) rr_ptr_d = '0;
            else                             rr_ptr_d = winner + PTR_W'(1);
        end else if (bus.data_gnt_i) begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            rr_ptr_q <= '0;
            add_q    <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            id_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
            add_q    <= add_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            id_q     <= id_d;
        end
    end

    // Slave-side outputs come straight from the register
    always_comb begin
        bus.data_req_o   = valid_q;
        bus.data_add_o   = add_q;
        bus.data_wen_o   = wen_q;
        bus.data_wdata_o = wdata_q;
        bus.data_be_o    = be_q;
        bus.data_ID_o    = id_q;
    end
endmodule

// File: doc/per2slave_rr_arb.md
PER2SLAVE_RR_ARB -- requirements
Module: per2slave_rr_arb

Interface
REQ-001 SHALL have parameter N_MASTER, default 16: number of requesting address-decoder ports.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: request address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: write data width; BE_WIDTH = DATA_WIDTH/8.
REQ-004 SHALL have parameter ID_WIDTH, default 17: requester ID width, forwarded unchanged.
REQ-005 SHALL use one clock and a synchronous, active-low reset, with ports: clk  in  1  clock; rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have port data_req_i  in  N_MASTER  per-master request for this slave (decoder data_req_o bit).
REQ-007 SHALL have ports data_add_i  in  N_MASTER x ADDR_WIDTH; data_wen_i  in  N_MASTER (1 = read); data_wdata_i  in  N_MASTER x DATA_WIDTH; data_be_i  in  N_MASTER x BE_WIDTH; data_ID_i  in  N_MASTER x ID_WIDTH.
REQ-008 SHALL have port data_gnt_o  out  N_MASTER  per-master grant (decoder data_gnt_i bit).
REQ-009 SHALL have ports data_req_o  out  1; data_add_o  out  ADDR_WIDTH; data_wen_o  out  1; data_wdata_o  out  DATA_WIDTH; data_be_o  out  BE_WIDTH; data_ID_o  out  ID_WIDTH: registered slave-side request.
REQ-010 SHALL have port data_gnt_i  in  1  slave grant.

Function
REQ-011 SHALL hold one output register (valid bit + payload); data_req_o = valid bit.
REQ-012 Register SHALL be "free" when valid=0 or (valid=1 and data_gnt_i=1) in the current cycle.
REQ-013 When free and any data_req_i set, SHALL select winner by round-robin: first set bit at or above pointer rr_ptr, wrapping from N_MASTER-1 to 0.
REQ-014 In that cycle SHALL assert data_gnt_o[winner]=1 (combinational, one-hot), capture winner payload at next edge, set valid=1.
REQ-015 data_gnt_o SHALL be all-zero when register not free or no request pending; never more than one bit set.
REQ-016 On capture, rr_ptr SHALL become (winner+1) mod N_MASTER; otherwise unchanged.
REQ-017 When valid=1 and data_gnt_i=1 and no new capture, valid SHALL clear at next edge.
REQ-018 Simultaneous drain and capture SHALL yield back-to-back requests: one transfer per cycle sustained, no bubble.
REQ-019 While valid=1 and data_gnt_i=0, all data_*_o SHALL stay stable.
REQ-020 Latency master grant -> data_req_o SHALL be exactly 1 cycle.
REQ-021 Masters deasserting data_req_i without grant SHALL be tolerated; no state is kept for ungranted requests.
REQ-022 rr_ptr SHALL be ceil(log2(N_MASTER)) bits; N_MASTER=1 SHALL degenerate to a 1-entry pipeline register.

Reset
REQ-023 While rst_n=0 at a clock edge: valid=0, rr_ptr=0, payload registers=0.
REQ-024 During and after reset: data_req_o=0, data_gnt_o=0 when not free; outputs data_add_o/wdata_o/be_o/ID_o=0, data_wen_o=0.
REQ-025 Reset mid-transfer SHALL drop the buffered request; no grant is re-issued for it.

Verification (bench N_MASTER=4)
REQ-026 Single: req_i=4'b0100, add[2]=0x1A10_2004, gnt_i=1 -> gnt_o=4'b0100 cycle 0; req_o=1, add_o=0x1A10_2004, ID_o=ID[2] cycle 1; rr_ptr=3.
REQ-027 Fairness: req_i=4'b1111 held, gnt_i=1 -> gnt_o sequence 0001,0010,0100,1000,0001; req_o continuously 1 from cycle 1.
REQ-028 Backpressure: valid=1, gnt_i=0 for 3 cycles, req_i=4'b0011 -> gnt_o=0 and outputs stable 3 cycles; on gnt_i=1 gnt_o=0001 same cycle, new payload next cycle.
REQ-029 Wrap: rr_ptr=3, req_i=4'b0011 -> gnt_o=0001, rr_ptr->1.
REQ-030 Reset mid-op: valid=1, gnt_i=0, rst_n=0 one edge -> req_o=0, rr_ptr=0; then req_i=4'b1000 -> gnt_o=1000.
REQ-031 Idle drain: valid=1, gnt_i=1, req_i=0 -> req_o=0 next cycle, gnt_o=0.
